// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin pair plus decoded key outputs, grouped for the decoder and its consumers.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    logic [4:0] direction;
    logic [4:0] number;

    // Keyboard side (drives the pins, observes decoded results)
    modport master (
        output ps2_clk,
        output ps2_dat,
        input  scan_code,
        input  code_valid,
        input  frame_err,
        input  direction,
        input  number
    );

    // Decoder side
    modport slave (
        input  ps2_clk,
        input  ps2_dat,
        output scan_code,
        output code_valid,
        output frame_err,
        output direction,
        output number
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw pins, frames 11-bit packets
// with odd parity, and maps arrow / digit make codes onto one-hot outputs.
module ps2_key_decoder #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    ps2_key_decoder_if.slave bus
);
    localparam int unsigned TMO_W  = 20;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEL_W  = 5;

    localparam logic [BYTE_W-1:0] CODE_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] CODE_BRK   = 8'hF0;
    localparam logic [BYTE_W-1:0] CODE_UP    = 8'h75;
    localparam logic [BYTE_W-1:0] CODE_LEFT  = 8'h6B;
    localparam logic [BYTE_W-1:0] CODE_DOWN  = 8'h72;
    localparam logic [BYTE_W-1:0] CODE_RIGHT = 8'h74;
    localparam logic [BYTE_W-1:0] CODE_KEY1  = 8'h16;
    localparam logic [BYTE_W-1:0] CODE_KEY2  = 8'h1E;
    localparam logic [BYTE_W-1:0] CODE_KEY3  = 8'h26;

    localparam logic [SEL_W-1:0] SEL_1 = 5'b00010;
    localparam logic [SEL_W-1:0] SEL_2 = 5'b00100;
    localparam logic [SEL_W-1:0] SEL_3 = 5'b01000;
    localparam logic [SEL_W-1:0] SEL_4 = 5'b10000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [BYTE_W-1:0]   scan_code_q, scan_code_d;
    logic                code_valid_q, code_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [SEL_W-1:0]    direction_q, direction_d;
    logic [SEL_W-1:0]    number_q, number_d;

    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic ps2_dat_meta_q, ps2_dat_sync_q;
    logic fall_c;

    // Two-flop synchronizers plus one history flop for edge detection; idle-high reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_meta_q <= 1'b1;
            ps2_clk_sync_q <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_dat_meta_q <= 1'b1;
            ps2_dat_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q <= bus.ps2_clk;
            ps2_clk_sync_q <= ps2_clk_meta_q;
            ps2_clk_prev_q <= ps2_clk_sync_q;
            ps2_dat_meta_q <= bus.ps2_dat;
            ps2_dat_sync_q <= ps2_dat_meta_q;
        end
    end

    assign fall_c = ps2_clk_prev_q & ~ps2_clk_sync_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            scan_code_q  <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            direction_q  <= '0;
            number_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            scan_code_q  <= scan_code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            direction_q  <= direction_d;
            number_q     <= number_d;
        end
    end

    // Frame FSM, timeout watchdog and key decode
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = tmo_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        scan_code_d  = scan_code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        direction_d  = direction_q;
        number_d     = number_q;

        if ((state_q == IDLE) || fall_c) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            IDLE: begin
                // A high start bit is line noise, not a frame
                if (fall_c && !ps2_dat_sync_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall_c) begin
                    shift_d   = {ps2_dat_sync_q, shift_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_c) begin
                    parity_d = ps2_dat_sync_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    state_d = IDLE;
                    if (ps2_dat_sync_q && (^{shift_q, parity_q})) begin
                        code_valid_d = 1'b1;
                        scan_code_d  = shift_q;
                        if (shift_q == CODE_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == CODE_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                            // Only make codes move the held selections
                            if (!brk_q) begin
                                case (shift_q)
                                    CODE_UP:    direction_d = SEL_1;
                                    CODE_LEFT:  direction_d = SEL_2;
                                    CODE_DOWN:  direction_d = SEL_3;
                                    CODE_RIGHT: direction_d = SEL_4;
                                    CODE_KEY1:  if (!ext_q) number_d = SEL_1;
                                    CODE_KEY2:  if (!ext_q) number_d = SEL_2;
                                    CODE_KEY3:  if (!ext_q) number_d = SEL_3;
                                    default:    ;
                                endcase
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandon a stalled frame; a half-received prefix sequence is no longer trustworthy
        if ((state_q != IDLE) && !fall_c && (tmo_d == TIMEOUT_CYCLES)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end
    end

    assign bus.scan_code  = scan_code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.direction  = direction_q;
    assign bus.number     = number_q;

endmodule
